lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
Memory-access stage directly downstream of the ALU in the NPC RV64 core. Consumes the ALU result (effective address or arithmetic result), the rs2 store data and the instruction's funct3/rd. Drives a single-outstanding valid/ready request port to data memory and produces an aligned, sign- or zero-extended writeback value. Non-memory instructions pass the ALU result through with fixed 1-cycle latency.

Parameters:
XLEN, 64, datapath and address width; memory port is XLEN/8 bytes wide.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream (ALU) result valid
in_ready  out  1  stage can accept; equals (state==IDLE)
in_op  in  2  00 pass-through, 01 load, 10 store, 11 reserved (treated as pass-through)
in_funct3  in  3  RISC-V funct3 of load/store
in_addr  in  XLEN  ALU result / effective address
in_wdata  in  XLEN  store data (rs2)
in_rd  in  5  destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=store, 0=load
mem_req_addr  out  XLEN  in_addr with bits [2:0] cleared
mem_req_wdata  out  XLEN  store data shifted into byte lane
mem_req_wstrb  out  8  byte enables (0 for loads)
mem_resp_valid  in  1  response/ack valid (single cycle)
mem_resp_rdata  in  XLEN  load data, full 8-byte word
out_valid  out  1  writeback result valid
out_ready  in  1  downstream accepts result
out_data  out  XLEN  writeback value
out_rd  out  5  destination register
out_we  out  1  register write enable
out_fault  out  1  misaligned or illegal-size access

Behaviour:
- Reset: state=IDLE; mem_req_valid, mem_req_we, out_valid, out_we, out_fault = 0; mem_req_addr, mem_req_wdata, out_data = 0; mem_req_wstrb=0; out_rd=0. Reset mid-transaction abandons it; no request is reissued.
- States: IDLE, REQ, WAIT, DONE. Input captured on in_valid && in_ready.
- IDLE: on capture: pass-through -> DONE (out_data=in_addr, out_we=(rd!=0)), 1-cycle latency; fault -> DONE (out_fault=1, out_we=0, out_data=in_addr, no memory request); load/store -> REQ with mem_req_* registered.
- REQ: mem_req_valid=1; fields held stable until mem_req_ready. On handshake -> WAIT, mem_req_valid=0 next cycle.
- WAIT: on mem_resp_valid -> DONE. Load: out_data = extended lane data, out_we=(rd!=0). Store: out_data=0, out_we=0. mem_resp_valid outside WAIT ignored (includes stray response after reset).
- DONE: out_valid=1, all out_* held until out_ready; on out_ready -> IDLE. No new input accepted until back in IDLE (in_ready=0 outside IDLE).
- Size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double. Loads: funct3[2]=1 is unsigned (LBU/LHU/LWU); funct3=111 -> fault. Stores: funct3[2]=1 -> fault.
- Alignment: fault if addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for double.
- Byte lane s=addr[2:0]. wstrb = ((1<<bytes)-1) << s. wdata = in_wdata << (8*s).
- Load extract: rdata >> (8*s), truncate to size, sign-extend (signed) or zero-extend (unsigned) to XLEN.

Test Plan:
- Pass-through: op=00, addr=0x1234, rd=5 -> out_valid the cycle after capture, out_data=0x1234, out_we=1; same with rd=0 -> out_we=0.
- LB at 0x1003, rdata=0x0000_0000_8000_0000 -> req addr 0x1000, wstrb=0; out_data=0xFFFF_FFFF_FFFF_FF80. LBU same -> 0x80.
- SH at 0x2006, rs2=0xABCD -> mem_req_we=1, addr 0x2000, wstrb=0xC0, wdata=0xABCD_0000_0000_0000; after ack out_we=0.
- Backpressure: mem_req_ready low 3 cycles, then resp delayed 2 cycles, out_ready low 2 cycles -> request fields stable, single handshake each, in_ready=0 throughout, out_* stable.
- Faults: LW at 0x1002 and SD at 0x3004 -> no mem_req_valid, out_fault=1, out_we=0; funct3=111 load -> fault.
- Reset while in WAIT, then stray mem_resp_valid -> stays IDLE, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/response bus between the LSU memory stage (master) and data memory (slave).
// The bus allows one outstanding request; responses are single-cycle pulses.
interface lsu_mem_stage_if #(
    parameter int XLEN = 64
) ();
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_we;
    logic [XLEN-1:0]     mem_req_addr;
    logic [XLEN-1:0]     mem_req_wdata;
    logic [XLEN/8-1:0]   mem_req_wstrb;
    logic                mem_resp_valid;
    logic [XLEN-1:0]     mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV64 memory-access stage: issues aligned load/store requests, extends load data and passes
// non-memory results through with one cycle of latency. Handles one instruction at a time.
module lsu_mem_stage #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    lsu_mem_stage_if.master   mem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_fault
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [LB-1:0]   lane_q;

    logic [1:0]      size;
    logic [LB-1:0]   lane;
    logic            is_mem;
    logic            is_load;
    logic            misaligned;
    logic            illegal;
    logic            fault;
    logic [NB-1:0]   byte_mask;
    logic [NB-1:0]   wstrb_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    assign in_ready = (state == IDLE);

    // Decode of the incoming instruction; only meaningful on the capture cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        size       = in_funct3[1:0];
        lane       = in_addr[LB-1:0];
        is_load    = (in_op == 2'b01);
        is_mem     = (in_op == 2'b01) || (in_op == 2'b10);
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = in_addr[0];
            2'b10:   misaligned = |in_addr[1:0];
            2'b11:   misaligned = |in_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        illegal   = is_load ? (in_funct3 == 3'b111) : in_funct3[2];
        fault     = is_mem && (misaligned || illegal);
        byte_mask = NB'((32'd1 << (32'd1 << size)) - 32'd1);
        wstrb_c   = byte_mask << lane;
        wdata_c   = in_wdata << {lane, 3'b000};
    end

    // Lane extraction and sign/zero extension of the returned memory word.
    always_comb begin
        shifted  = mem.mem_resp_rdata >> {lane_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = {{(XLEN-8){~unsigned_q & shifted[7]}},   shifted[7:0]};
            2'b01:   load_ext = {{(XLEN-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
            2'b10:   load_ext = {{(XLEN-32){~unsigned_q & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every update
    // in this block sees the pre-edge values, matching the flip-flops it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            size_q            <= 2'b00;
            unsigned_q        <= 1'b0;
            lane_q            <= '0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_req_we    <= 1'b0;
            mem.mem_req_addr  <= '0;
            mem.mem_req_wdata <= '0;
            mem.mem_req_wstrb <= '0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_rd            <= '0;
            out_we            <= 1'b0;
            out_fault         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_rd <= in_rd;
                        if (!is_mem || fault) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_addr;
                            out_fault <= fault;
                            out_we    <= !fault && (in_rd != 5'd0);
                        end else begin
                            state             <= REQ;
                            size_q            <= size;
                            unsigned_q        <= in_funct3[2];
                            lane_q            <= lane;
                            mem.mem_req_valid <= 1'b1;
                            mem.mem_req_we    <= !is_load;
                            mem.mem_req_addr  <= {in_addr[XLEN-1:LB], LB'(0)};
                            mem.mem_req_wdata <= is_load ? '0 : wdata_c;
                            mem.mem_req_wstrb <= is_load ? '0 : wstrb_c;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_req_ready) begin
                        state             <= WAIT;
                        mem.mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem.mem_resp_valid) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_fault <= 1'b0;
                        if (mem.mem_req_we) begin
                            out_data <= '0;
                            out_we   <= 1'b0;
                        end else begin
                            out_data <= load_ext;
                            out_we   <= (out_rd != 5'd0);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_we    <= 1'b0;
                        out_fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
